// File: rtl/note_sequencer.sv
// Note sequencer: walks the selected song's ROM entries, issues each {note, duration}
// to the note player and pulses song_done at the end. NOTE_SEQ_END_MARKER_EN enables duration==0 end markers.
module note_sequencer #(
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [1:0]              song,
    output logic [IDX_W+1:0]        rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    input  logic                    note_done,
    output logic                    new_note,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    song_done,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_ISSUE   = 3'd3,
        S_PLAYING = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;

    assign rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur   = rom_data[DUR_W-1:0];

    // Song is not registered: whatever song is selected at fetch time is read.
    assign rom_addr  = {song, idx_q};
    assign note      = note_q;
    assign duration  = dur_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        note_d    = note_q;
        dur_d     = dur_q;
        new_note  = 1'b0;
        song_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (play) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                note_d  = rom_note;
                dur_d   = rom_dur;
                state_d = S_ISSUE;
`ifdef NOTE_SEQ_END_MARKER_EN
                if (rom_dur == '0) state_d = S_DONE;
`endif
            end
            S_ISSUE: begin
                new_note = 1'b1;
                state_d  = S_PLAYING;
            end
            S_PLAYING: begin
                if (note_done) begin
                    // The last entry always ends the song; idx never wraps.
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = play ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_DONE: begin
                song_done = 1'b1;
                idx_d     = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios, a registered ROM model and a
// scoreboard of expected new_note / song_done events checked by a monitor.
module tb_note_sequencer;

  localparam int W = 21;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_WAIT = 3'd2,
                         ST_PLAYING = 3'd4, ST_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic [1:0]  song = 2'd0;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data = 12'd0;
  logic        note_done = 1'b0;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        song_done;
  logic [2:0]  dbg_state;

  logic [11:0]  rom [128];
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  note_sequencer #(.IDX_W(5), .NOTE_W(6), .DUR_W(6)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .rom_addr(rom_addr),
    .rom_data(rom_data), .note_done(note_done), .new_note(new_note), .note(note),
    .duration(duration), .song_done(song_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // registered song ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    for (int a = 0; a < 128; a++) begin
      rom[a] = {6'((a * 5 + 1) % 64), 6'((a % 61) + 1)};
    end
    rom[7'h40] = {6'd12, 6'd5};
    rom[7'h41] = {6'd7, 6'd3};
    rom[7'h03] = {6'd9, 6'd0};
  end

  // scoreboard monitor: every new_note / song_done must match the queue head
  always @(negedge clk) begin
    if (new_note || song_done) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      got = {song_done, new_note, rom_addr, note, duration};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got %h, expected no event", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL event: got %h, expected %h", got, exp);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push_note(input logic [6:0] addr);
    exp_q.push_back({1'b0, 1'b1, addr, rom[addr]});
  endtask

  task automatic push_done(input logic [6:0] addr, input logic [11:0] word);
    exp_q.push_back({1'b1, 1'b0, addr, word});
  endtask

  // new_note must appear in the third cycle after the trigger cycle c0
  // (four cycles counting the note_done cycle itself) and last one cycle.
  task automatic expect_issue(input int c0, input string name);
    bit seen = 0;
    int at = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (new_note) begin
        seen = 1;
        at = cyc;
      end
    end
    vectors++;
    if (!seen || at - c0 != 3) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0b), expected 3", name, at - c0, seen);
    end
    @(negedge clk);
    check({name, "_width"}, {31'd0, new_note}, 32'd0);
  endtask

  task automatic finish_note(input logic pl, output int c0);
    tick();
    tick();
    play = pl;
    note_done = 1'b1;
    c0 = cyc;
    tick();
    note_done = 1'b0;
  endtask

  initial begin
    int c0;
    // reset
    repeat (3) tick();
    @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_addr", rom_addr, 7'h00);
    check("rst_new_note", new_note, 0);
    check("rst_song_done", song_done, 0);
    check("rst_note", note, 0);
    check("rst_duration", duration, 0);

    // first note of song 2
    tick();
    reset = 1'b0;
    song = 2'd2;
    play = 1'b1;
    push_note(7'h40);
    c0 = cyc;
    @(negedge clk);
    @(negedge clk);
    check("fetch_state", dbg_state, ST_FETCH);
    check("fetch_addr", rom_addr, 7'h40);
    expect_issue(c0, "first");
    repeat (3) @(negedge clk);
    check("hold_state", dbg_state, ST_PLAYING);
    check("hold_note", note, 12);
    check("hold_duration", duration, 5);

    // next note after note_done with play held
    push_note(7'h41);
    finish_note(1'b1, c0);
    @(negedge clk);
    check("next_addr", rom_addr, 7'h41);
    expect_issue(c0, "next");
    check("next_note", note, 7);
    check("next_duration", duration, 3);

    // play dropped during WAIT still issues the note
    push_note(7'h42);
    finish_note(1'b1, c0);
    tick();
    @(negedge clk);
    check("pause_wait_state", dbg_state, ST_WAIT);
    play = 1'b0;
    expect_issue(c0, "pause_issue");

    // note_done with play low: idle with idx advanced, address stable
    finish_note(1'b0, c0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("paused_state", dbg_state, ST_IDLE);
      check("paused_addr", rom_addr, 7'h43);
    end
    tick();
    push_note(7'h43);
    play = 1'b1;
    c0 = cyc;
    expect_issue(c0, "resume");

    // reset mid-note, coincident with note_done
    tick();
    reset = 1'b1;
    note_done = 1'b1;
    play = 1'b0;
    tick();
    reset = 1'b0;
    note_done = 1'b0;
    @(negedge clk);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_addr", rom_addr, 7'h40);
    check("midrst_note", note, 0);
    check("midrst_duration", duration, 0);
    check("midrst_song_done", song_done, 0);

    // full song 1: 32 notes then song_done
    tick();
    song = 2'd1;
    play = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 32; i++) begin
      push_note({2'd1, 5'(i)});
      expect_issue(c0, "song1");
      if (i == 31) begin
        push_done(7'h3F, rom[7'h3F]);
        finish_note(1'b0, c0);
      end else begin
        finish_note(1'b1, c0);
      end
    end
    @(negedge clk);
    check("done_state", dbg_state, ST_DONE);
    check("done_pulse", song_done, 1);
    tick();
    @(negedge clk);
    check("after_done_state", dbg_state, ST_IDLE);
    check("after_done_pulse", song_done, 0);
    check("after_done_addr", rom_addr, 7'h20);

    // song 0: entry 3 carries duration 0
    tick();
    song = 2'd0;
    play = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      push_note(7'(i));
      expect_issue(c0, "song0");
      if (i < 2) finish_note(1'b1, c0);
    end
`ifdef NOTE_SEQ_END_MARKER_EN
    push_done(7'h03, {6'd9, 6'd0});
    finish_note(1'b0, c0);
    repeat (8) @(negedge clk);
    check("marker_state", dbg_state, ST_IDLE);
    check("marker_addr", rom_addr, 7'h00);
`else
    push_note(7'h03);
    finish_note(1'b1, c0);
    expect_issue(c0, "zero_dur");
    check("zero_dur_note", note, 9);
    check("zero_dur_duration", duration, 0);
    play = 1'b0;
`endif

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
